// File: rtl/caxi4interconnect_dwc_wchan_reg_slice.sv
//----------------------------------------------------------------------------
// caxi4interconnect_dwc_wchan_reg_slice
//
// Two-entry skid buffer for the AXI4 W channel. It sits on the output of the
// data-width down-converter. The main register M drives SLAVE_W*. The skid
// register S catches one beat when the downstream side stalls while the
// upstream side is still pushing. Every output comes straight from a flop, so
// there is no combinational path from any input to any output.
//
// Handshake: a beat moves on a rising ACLK edge where valid and ready are both
// high. Upstream transfer = MASTER_WVALID & MASTER_WREADY. Downstream transfer
// = SLAVE_WVALID & SLAVE_WREADY. While SLAVE_WVALID is high and no transfer
// has happened, SLAVE_WVALID and the SLAVE_W* payload do not change.
//
// Ports
//   ACLK, sysReset       clock; asynchronous active-low reset
//   MASTER_W*            upstream payload, valid in, ready out
//   SLAVE_W*             downstream payload, valid out, ready in
//   OCCUPANCY            beats held (0..2); this is also the FSM state
//----------------------------------------------------------------------------
module caxi4interconnect_dwc_wchan_reg_slice #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
) (
  input  logic                  ACLK,
  input  logic                  sysReset,
  input  logic [ID_WIDTH-1:0]   MASTER_WID,
  input  logic [DATA_WIDTH-1:0] MASTER_WDATA,
  input  logic [STRB_WIDTH-1:0] MASTER_WSTRB,
  input  logic                  MASTER_WLAST,
  input  logic [USER_WIDTH-1:0] MASTER_WUSER,
  input  logic                  MASTER_WVALID,
  output logic                  MASTER_WREADY,
  output logic [ID_WIDTH-1:0]   SLAVE_WID,
  output logic [DATA_WIDTH-1:0] SLAVE_WDATA,
  output logic [STRB_WIDTH-1:0] SLAVE_WSTRB,
  output logic                  SLAVE_WLAST,
  output logic [USER_WIDTH-1:0] SLAVE_WUSER,
  output logic                  SLAVE_WVALID,
  input  logic                  SLAVE_WREADY,
  output logic [1:0]            OCCUPANCY
);

  localparam int PW = ID_WIDTH + DATA_WIDTH + STRB_WIDTH + 1 + USER_WIDTH;

  // The encoding equals the number of beats held; OCCUPANCY mirrors it.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   m_q, m_d;
  logic [PW-1:0]   s_q, s_d;
  logic            wready_q, wready_d;
  logic            wvalid_q, wvalid_d;
  logic [1:0]      occ_q, occ_d;

  logic [PW-1:0]   in_pl;
  logic            up_xfer;
  logic            dn_xfer;

  assign in_pl   = {MASTER_WID, MASTER_WDATA, MASTER_WSTRB, MASTER_WLAST, MASTER_WUSER};
  assign up_xfer = MASTER_WVALID & wready_q;
  assign dn_xfer = wvalid_q & SLAVE_WREADY;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (up_xfer) begin
          m_d     = in_pl;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (up_xfer && dn_xfer) begin
          // M leaves and the new beat replaces it on the same edge.
          m_d = in_pl;
        end else if (up_xfer) begin
          s_d     = in_pl;
          state_d = ST_FULL;
        end else if (dn_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // wready_q is low here, so no upstream beat can arrive.
        if (dn_xfer) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    wready_d = (state_d != ST_FULL);
    wvalid_d = (state_d != ST_EMPTY);
    occ_d    = state_d;
  end

  always_ff @(posedge ACLK or negedge sysReset) begin
    if (!sysReset) begin
      state_q  <= ST_EMPTY;
      m_q      <= '0;
      s_q      <= '0;
      wready_q <= 1'b1;
      wvalid_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      s_q      <= s_d;
      wready_q <= wready_d;
      wvalid_q <= wvalid_d;
      occ_q    <= occ_d;
    end
  end

  assign MASTER_WREADY = wready_q;
  assign SLAVE_WVALID  = wvalid_q;
  assign OCCUPANCY     = occ_q;
  assign {SLAVE_WID, SLAVE_WDATA, SLAVE_WSTRB, SLAVE_WLAST, SLAVE_WUSER} = m_q;

endmodule

// File: tb/tb_caxi4interconnect_dwc_wchan_reg_slice.sv
//----------------------------------------------------------------------------
// Bench for caxi4interconnect_dwc_wchan_reg_slice.
// Reference model: a queue of held beats with capacity 2. The slice is ready
// when the queue holds fewer than 2 beats, valid when it holds any, and the
// presented payload is the head of the queue.
//----------------------------------------------------------------------------
module tb_caxi4interconnect_dwc_wchan_reg_slice;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int IW = 4;
  localparam int UW = 2;
  localparam int PW = IW + DW + SW + 1 + UW;
  localparam int N_RAND = 10000;

  logic          ACLK;
  logic          sysReset;
  logic [IW-1:0] MASTER_WID;
  logic [DW-1:0] MASTER_WDATA;
  logic [SW-1:0] MASTER_WSTRB;
  logic          MASTER_WLAST;
  logic [UW-1:0] MASTER_WUSER;
  logic          MASTER_WVALID;
  logic          MASTER_WREADY;
  logic [IW-1:0] SLAVE_WID;
  logic [DW-1:0] SLAVE_WDATA;
  logic [SW-1:0] SLAVE_WSTRB;
  logic          SLAVE_WLAST;
  logic [UW-1:0] SLAVE_WUSER;
  logic          SLAVE_WVALID;
  logic          SLAVE_WREADY;
  logic [1:0]    OCCUPANCY;

  caxi4interconnect_dwc_wchan_reg_slice #(
    .DATA_WIDTH(DW), .STRB_WIDTH(SW), .ID_WIDTH(IW), .USER_WIDTH(UW)
  ) dut (
    .ACLK(ACLK), .sysReset(sysReset),
    .MASTER_WID(MASTER_WID), .MASTER_WDATA(MASTER_WDATA),
    .MASTER_WSTRB(MASTER_WSTRB), .MASTER_WLAST(MASTER_WLAST),
    .MASTER_WUSER(MASTER_WUSER), .MASTER_WVALID(MASTER_WVALID),
    .MASTER_WREADY(MASTER_WREADY),
    .SLAVE_WID(SLAVE_WID), .SLAVE_WDATA(SLAVE_WDATA),
    .SLAVE_WSTRB(SLAVE_WSTRB), .SLAVE_WLAST(SLAVE_WLAST),
    .SLAVE_WUSER(SLAVE_WUSER), .SLAVE_WVALID(SLAVE_WVALID),
    .SLAVE_WREADY(SLAVE_WREADY), .OCCUPANCY(OCCUPANCY)
  );

  // ---------------- clock ----------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            delivered = 0;
  logic [PW-1:0] exp_q[$];
  logic          stall_chk = 1'b0;
  logic [PW-1:0] stall_pl  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] dut_pl();
    return {SLAVE_WID, SLAVE_WDATA, SLAVE_WSTRB, SLAVE_WLAST, SLAVE_WUSER};
  endfunction

  function automatic logic [PW-1:0] in_pl();
    return {MASTER_WID, MASTER_WDATA, MASTER_WSTRB, MASTER_WLAST, MASTER_WUSER};
  endfunction

  // Model update on each edge, from the values present just before it.
  always @(posedge ACLK) begin
    if (!sysReset) begin
      exp_q.delete();
      stall_chk <= 1'b0;
    end else begin
      int  sz;
      logic up, dn;
      sz = exp_q.size();
      up = MASTER_WVALID && (sz < 2);
      dn = (sz > 0) && SLAVE_WREADY;
      if (dn) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (up) exp_q.push_back(in_pl());
      stall_chk <= SLAVE_WVALID && !SLAVE_WREADY;
      stall_pl  <= dut_pl();
    end
  end

  always @(negedge sysReset) begin
    exp_q.delete();
    stall_chk <= 1'b0;
  end

  // Compare process: DUT against the model on every falling edge.
  always @(negedge ACLK) begin
    check("wready", MASTER_WREADY, exp_q.size() < 2);
    check("wvalid", SLAVE_WVALID, exp_q.size() > 0);
    check("occupancy", OCCUPANCY, exp_q.size());
    if (exp_q.size() > 0) check("payload", dut_pl(), exp_q[0]);
    if (stall_chk && sysReset) begin
      check("stall_valid_held", SLAVE_WVALID, 1'b1);
      check("stall_payload_held", dut_pl(), stall_pl);
    end
  end

  // ---------------- driver ----------------
  task automatic drive_full(input logic v, input logic [IW-1:0] id, input logic [DW-1:0] d,
                            input logic [SW-1:0] st, input logic l, input logic [UW-1:0] u,
                            input logic sr);
    MASTER_WVALID = v;
    MASTER_WID    = id;
    MASTER_WDATA  = d;
    MASTER_WSTRB  = st;
    MASTER_WLAST  = l;
    MASTER_WUSER  = u;
    SLAVE_WREADY  = sr;
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic sr);
    drive_full(v, '0, d, {SW{1'b1}}, l, '0, sr);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int cyc;
    sysReset = 1'b0;
    MASTER_WVALID = 1'b0; MASTER_WID = '0; MASTER_WDATA = '0; MASTER_WSTRB = '0;
    MASTER_WLAST = 1'b0; MASTER_WUSER = '0; SLAVE_WREADY = 1'b0;
    repeat (2) @(negedge ACLK);

    // Reset state, payload cleared.
    check("rst_wready", MASTER_WREADY, 1'b1);
    check("rst_wvalid", SLAVE_WVALID, 1'b0);
    check("rst_occ", OCCUPANCY, 2'd0);
    check("rst_payload", dut_pl(), '0);
    sysReset = 1'b1;

    // Streaming 0..15 with ready high: one cycle latency, one beat per cycle.
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, k, k == 15, 1'b1);
      check("stream_valid", SLAVE_WVALID, 1'b1);
      check("stream_data", SLAVE_WDATA, k);
      check("stream_last", SLAVE_WLAST, k == 15);
      check("stream_occ", OCCUPANCY, 2'd1);
    end
    drive(1'b0, 0, 1'b0, 1'b1);
    check("stream_drained", SLAVE_WVALID, 1'b0);

    // Fill to FULL under stall, then release.
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    check("fill_occ1", OCCUPANCY, 2'd1);
    check("fill_data1", SLAVE_WDATA, 32'h11);
    drive(1'b1, 32'h22, 1'b1, 1'b0);
    check("fill_occ2", OCCUPANCY, 2'd2);
    check("fill_wready0", MASTER_WREADY, 1'b0);
    check("fill_data_held", SLAVE_WDATA, 32'h11);
    drive(1'b1, 32'h99, 1'b0, 1'b0);   // ignored, slice not ready
    check("full_ignore_occ", OCCUPANCY, 2'd2);
    check("full_ignore_data", SLAVE_WDATA, 32'h11);
    drive(1'b0, 0, 1'b0, 1'b1);
    check("rel_occ1", OCCUPANCY, 2'd1);
    check("rel_data22", SLAVE_WDATA, 32'h22);
    check("rel_last", SLAVE_WLAST, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b1);
    check("rel_occ0", OCCUPANCY, 2'd0);
    check("rel_valid0", SLAVE_WVALID, 1'b0);

    // Simultaneous up and down transfer in ONE.
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 1'b0, 1'b1);
    check("both_occ", OCCUPANCY, 2'd1);
    check("both_data", SLAVE_WDATA, 32'h33);
    drive(1'b0, 0, 1'b0, 1'b1);
    check("both_drained", OCCUPANCY, 2'd0);

    // Asynchronous reset while FULL.
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    drive(1'b1, 32'h66, 1'b0, 1'b0);
    check("prerst_occ", OCCUPANCY, 2'd2);
    #2;
    sysReset = 1'b0;
    #1;
    check("arst_wvalid", SLAVE_WVALID, 1'b0);
    check("arst_occ", OCCUPANCY, 2'd0);
    check("arst_wready", MASTER_WREADY, 1'b1);
    MASTER_WVALID = 1'b0;
    SLAVE_WREADY  = 1'b1;
    @(negedge ACLK);
    sysReset = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b1);
    check("postrst_no_stale", SLAVE_WVALID, 1'b0);
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    check("postrst_accept_occ", OCCUPANCY, 2'd1);
    check("postrst_accept_data", SLAVE_WDATA, 32'h77);
    drive(1'b0, 0, 1'b0, 1'b1);

    // Random traffic with random payload fields.
    delivered = 0;
    cyc = 0;
    while (delivered < N_RAND && cyc < 60000) begin
      drive_full($urandom_range(0, 3) != 0, IW'($urandom), $urandom,
                 SW'($urandom), 1'($urandom), UW'($urandom),
                 $urandom_range(0, 3) != 0);
      cyc++;
    end
    check("random_delivered", delivered >= N_RAND, 1'b1);
    repeat (3) drive(1'b0, 0, 1'b0, 1'b1);
    check("random_final_occ", OCCUPANCY, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/caxi4interconnect_dwc_wchan_reg_slice.md
CAXI4INTERCONNECT_DWC_WCHAN_REG_SLICE -- requirements
Module: caxi4interconnect_dwc_wchan_reg_slice

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, slave-side W data width (down-converter output width).
REQ-002 SHALL have parameter STRB_WIDTH, default 4, equal to DATA_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 1, WID width.
REQ-004 SHALL have parameter USER_WIDTH, default 1, WUSER width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: ACLK input, sysReset input, asynchronous active-low.
REQ-006 ACLK  in  1  sole clock; all flops rising-edge.
REQ-007 sysReset  in  1  asynchronous active-low reset.
REQ-008 MASTER_WID/WDATA/WSTRB/WLAST/WUSER  in  ID_WIDTH/DATA_WIDTH/STRB_WIDTH/1/USER_WIDTH  upstream W payload, from the down-converter's SLAVE_W side.
REQ-009 MASTER_WVALID  in  1  upstream beat valid.
REQ-010 MASTER_WREADY  out  1  slice can accept a beat.
REQ-011 SLAVE_WID/WDATA/WSTRB/WLAST/WUSER  out  same widths  downstream W payload.
REQ-012 SLAVE_WVALID  out  1  downstream beat valid.
REQ-013 SLAVE_WREADY  in  1  downstream slave accepts beat.
REQ-014 OCCUPANCY  out  2  beats held (0..2).

Function
REQ-015 SHALL be a 2-entry skid buffer: main register M drives SLAVE_W*; skid register S catches one beat when downstream stalls.
REQ-016 SHALL register all outputs (MASTER_WREADY, SLAVE_WVALID, SLAVE_W* payload, OCCUPANCY); no combinational path from any input to any output.
REQ-017 SHALL define upstream transfer as MASTER_WVALID&MASTER_WREADY, downstream transfer as SLAVE_WVALID&SLAVE_WREADY.
REQ-018 States: EMPTY (occ 0), ONE (M valid), FULL (M and S valid); OCCUPANCY SHALL equal state encoding 0/1/2.
REQ-019 EMPTY: MASTER_WREADY=1, SLAVE_WVALID=0; upstream transfer -> load M, go ONE.
REQ-020 ONE: MASTER_WREADY=1, SLAVE_WVALID=1; up only -> load S, go FULL; down only -> go EMPTY; both -> load M with new beat, stay ONE; neither -> hold.
REQ-021 FULL: MASTER_WREADY=0, SLAVE_WVALID=1; down transfer -> move S into M same edge, go ONE; else hold.
REQ-022 Latency SHALL be exactly 1 cycle from upstream transfer to SLAVE_WVALID when slice EMPTY.
REQ-023 Throughput SHALL be one beat per cycle with SLAVE_WREADY continuously high.
REQ-024 Beat order SHALL be preserved; every payload field (incl. WLAST, WID, WUSER) travels unmodified with its beat.
REQ-025 SHALL never drop or duplicate a beat; upstream transfer SHALL be impossible in FULL.
REQ-026 SLAVE_W* payload SHALL stay stable while SLAVE_WVALID=1 and SLAVE_WREADY=0.
REQ-027 SLAVE_WVALID, once asserted, SHALL NOT deassert until a downstream transfer.
REQ-028 MASTER_WVALID with MASTER_WREADY=0 SHALL have no effect on state.

Reset
REQ-029 sysReset low SHALL immediately force EMPTY: SLAVE_WVALID=0, MASTER_WREADY=1, OCCUPANCY=0, independent of ACLK.
REQ-030 Payload registers SHALL reset to all-zero.
REQ-031 Reset asserted mid-burst SHALL discard held beats; no beat SHALL be presented after deassertion until a new upstream transfer.
REQ-032 After sysReset deasserts, first upstream transfer SHALL be accepted on the first ACLK edge.

Verification
REQ-033 Stream 16 beats WDATA=0x0..0xF, SLAVE_WREADY=1 -> SLAVE side shows 0x0..0xF on consecutive cycles, first one cycle after first accept, WLAST only on 0xF.
REQ-034 Push A=0x11, B=0x22 with SLAVE_WREADY=0 -> OCCUPANCY 1 then 2, MASTER_WREADY=0, SLAVE_WDATA held 0x11; release -> 0x11 then 0x22, OCCUPANCY 2->1->0.
REQ-035 In ONE with simultaneous up (0x33) and down transfer -> OCCUPANCY stays 1, next SLAVE_WDATA=0x33.
REQ-036 Assert sysReset low while FULL -> SLAVE_WVALID=0, OCCUPANCY=0, MASTER_WREADY=1 asynchronously; no stale beat after release.
REQ-037 Random MASTER_WVALID/SLAVE_WREADY, 10000 beats, random WID/WSTRB/WUSER -> scoreboard exact in-order match, stability assertions (REQ-026/027) never fire.
